// File: rtl/song_autoplayer.sv
// Ode-to-Joy autoplayer and live-key arbiter for the shared tone generator.
// Optional macro SONG_LOOP_EN: restart the phrase at end-of-song instead of idling.
module song_autoplayer #(
  parameter int HALF_BEAT_CYCLES = 12_500_000,
  parameter int GAP_CYCLES       = 2_500_000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       play,
  input  logic       stop,
  input  logic [7:0] sw,
  output logic [3:0] note_out,
  output logic [7:0] led,
  output logic       playing,
  output logic       preempted,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, NOTE, GAP} state_t;

  state_t      state, state_n;
  logic [3:0]  idx, idx_n;
  logic [27:0] timer, timer_n;
  logic        done_n;
  logic [3:0]  live;

  function automatic logic [3:0] rom_note(input logic [3:0] i);
    case (i)
      4'd0, 4'd1, 4'd6, 4'd11, 4'd12: rom_note = 4'd3;
      4'd2, 4'd5:                     rom_note = 4'd4;
      4'd3, 4'd4:                     rom_note = 4'd5;
      4'd7, 4'd10, 4'd13, 4'd14:      rom_note = 4'd2;
      4'd8, 4'd9:                     rom_note = 4'd1;
      default:                        rom_note = 4'd0;
    endcase
  endfunction

  function automatic logic [2:0] rom_dur(input logic [3:0] i);
    case (i)
      4'd12:   rom_dur = 3'd3;
      4'd13:   rom_dur = 3'd1;
      4'd14:   rom_dur = 3'd4;
      default: rom_dur = 3'd2;
    endcase
  endfunction

  function automatic logic [27:0] note_len(input logic [3:0] i);
    note_len = 28'(rom_dur(i)) * 28'(HALF_BEAT_CYCLES);
  endfunction

  // Lowest set key wins: scan high to low so the lowest bit is written last.
  always_comb begin
    live = 4'd0;
    for (int k = 7; k >= 0; k--)
      if (sw[k]) live = 4'(k + 1);
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    timer_n = timer;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (play && !stop) begin
          state_n = NOTE;
          idx_n   = 4'd0;
          timer_n = note_len(4'd0);
        end
      end
      default: begin
        if (stop) begin
          state_n = IDLE;
          idx_n   = 4'd0;
          timer_n = 28'd0;
        end else if (sw == 8'd0) begin
          // Any key held freezes state, idx and timer; only advance when free.
          if (timer > 28'd1) begin
            timer_n = timer - 28'd1;
          end else if (state == NOTE && GAP_CYCLES != 0) begin
            state_n = GAP;
            timer_n = 28'(GAP_CYCLES);
          end else if (idx != 4'd14) begin
            state_n = NOTE;
            idx_n   = idx + 4'd1;
            timer_n = note_len(idx + 4'd1);
          end else begin
            done_n = 1'b1;
            idx_n  = 4'd0;
`ifdef SONG_LOOP_EN
            state_n = NOTE;
            timer_n = note_len(4'd0);
`else
            state_n = IDLE;
            timer_n = 28'd0;
`endif
          end
        end
      end
    endcase
  end

  // Outputs are registered from next-state values so they line up with state.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      idx       <= 4'd0;
      timer     <= 28'd0;
      note_out  <= 4'd0;
      led       <= 8'd0;
      playing   <= 1'b0;
      preempted <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      timer     <= timer_n;
      done      <= done_n;
      playing   <= (state_n != IDLE);
      preempted <= (state_n != IDLE) && (sw != 8'd0);
      led       <= (state_n != IDLE) ? (8'd1 << (rom_note(idx_n) - 4'd1)) : 8'd0;
      if (sw != 8'd0)
        note_out <= live;
      else if (state_n == NOTE)
        note_out <= rom_note(idx_n);
      else
        note_out <= 4'd0;
    end
  end

endmodule

// File: tb/tb_song_autoplayer.sv
// Directed bench for song_autoplayer with HALF_BEAT_CYCLES=4, GAP_CYCLES=2.
module tb_song_autoplayer;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       play = 1'b0, stop = 1'b0;
  logic [7:0] sw = 8'd0;
  logic [3:0] note_out;
  logic [7:0] led;
  logic       playing, preempted, done;

  int total = 0;
  int bad   = 0;

  song_autoplayer #(.HALF_BEAT_CYCLES(4), .GAP_CYCLES(2)) dut (
    .CLK(CLK), .RESET(RESET), .play(play), .stop(stop), .sw(sw),
    .note_out(note_out), .led(led), .playing(playing),
    .preempted(preempted), .done(done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       play;
    logic       stop;
    logic [7:0] sw;
    int         n;
    logic [3:0] note;
    logic [7:0] led;
    logic       playing;
    logic       pre;
    logic       done;
  } vec_t;

  vec_t tbl[19];

  int bn[15] = '{3,3,4,5,5,4,3,2,1,1,2,3,3,2,2};
  int bd[15] = '{2,2,2,2,2,2,2,2,2,2,2,2,3,1,4};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_all(input string name, input logic [3:0] n, input logic [7:0] l,
                         input logic p, input logic pr, input logic d);
    chk({name, ".note"}, 32'(note_out), 32'(n));
    chk({name, ".led"}, 32'(led), 32'(l));
    chk({name, ".playing"}, 32'(playing), 32'(p));
    chk({name, ".preempted"}, 32'(preempted), 32'(pr));
    chk({name, ".done"}, 32'(done), 32'(d));
  endtask

  initial begin
    int cnt;
    logic seen;

    // play, stop, sw, repeat, note, led, playing, preempted, done
    tbl[0]  = '{0, 0, 8'h00, 2, 4'd0, 8'h00, 0, 0, 0};
    tbl[1]  = '{0, 0, 8'h04, 1, 4'd3, 8'h00, 0, 0, 0};
    tbl[2]  = '{0, 0, 8'h80, 1, 4'd8, 8'h00, 0, 0, 0};
    tbl[3]  = '{0, 0, 8'h06, 1, 4'd2, 8'h00, 0, 0, 0};
    tbl[4]  = '{0, 0, 8'h00, 1, 4'd0, 8'h00, 0, 0, 0};
    tbl[5]  = '{1, 0, 8'h00, 1, 4'd3, 8'h04, 1, 0, 0};
    tbl[6]  = '{1, 0, 8'h00, 3, 4'd3, 8'h04, 1, 0, 0};
    tbl[7]  = '{0, 0, 8'h00, 4, 4'd3, 8'h04, 1, 0, 0};
    tbl[8]  = '{0, 0, 8'h00, 2, 4'd0, 8'h04, 1, 0, 0};
    tbl[9]  = '{0, 0, 8'h00, 8, 4'd3, 8'h04, 1, 0, 0};
    tbl[10] = '{0, 0, 8'h00, 2, 4'd0, 8'h04, 1, 0, 0};
    tbl[11] = '{0, 0, 8'h00, 3, 4'd4, 8'h08, 1, 0, 0};
    tbl[12] = '{0, 0, 8'hA0, 5, 4'd6, 8'h08, 1, 1, 0};
    tbl[13] = '{0, 0, 8'h00, 5, 4'd4, 8'h08, 1, 0, 0};
    tbl[14] = '{0, 0, 8'h00, 2, 4'd0, 8'h08, 1, 0, 0};
    tbl[15] = '{0, 0, 8'h00, 1, 4'd5, 8'h10, 1, 0, 0};
    tbl[16] = '{0, 1, 8'h00, 1, 4'd0, 8'h00, 0, 0, 0};
    tbl[17] = '{1, 1, 8'h00, 1, 4'd0, 8'h00, 0, 0, 0};
    tbl[18] = '{0, 0, 8'h00, 1, 4'd0, 8'h00, 0, 0, 0};

    // Reset state
    #2;
    chk_all("reset", 4'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    step();
    RESET = 1'b0;

    // Table: live keys in IDLE, first notes and gaps, preemption stretch, stop
    for (int v = 0; v < 19; v++) begin
      for (int r = 0; r < tbl[v].n; r++) begin
        play = tbl[v].play; stop = tbl[v].stop; sw = tbl[v].sw;
        step();
        chk_all($sformatf("vec%0d.%0d", v, r), tbl[v].note, tbl[v].led,
                tbl[v].playing, tbl[v].pre, tbl[v].done);
      end
    end
    play = 0; stop = 0; sw = 0;

    // Full song against the note table
    play = 1'b1;
    step();
    play = 1'b0;
    for (int i = 0; i < 15; i++) begin
      for (int c = 0; c < bd[i] * 4 + 2; c++) begin
        if (c < bd[i] * 4) chk($sformatf("song%0d.note", i), 32'(note_out), 32'(bn[i]));
        else               chk($sformatf("song%0d.note", i), 32'(note_out), 32'd0);
        chk($sformatf("song%0d.led", i), 32'(led), 32'(8'd1 << (bn[i] - 1)));
        chk($sformatf("song%0d.done", i), 32'(done), 32'd0);
        step();
      end
    end
    // 158 cycles after the first NOTE cycle
`ifdef SONG_LOOP_EN
    chk_all("end_loop", 4'd3, 8'h04, 1'b1, 1'b0, 1'b1);
`else
    chk_all("end", 4'd0, 8'h00, 1'b0, 1'b0, 1'b1);
`endif
    step();
    chk("end.done_pulse", 32'(done), 32'd0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop.playing", 32'(playing), 32'd0);

    // play+stop together during GAP of idx 5
    play = 1'b1;
    step();
    play = 1'b0;
    repeat (58) step();
    chk_all("gap5", 4'd0, 8'h08, 1'b1, 1'b0, 1'b0);
    play = 1'b1; stop = 1'b1;
    step();
    play = 1'b0; stop = 1'b0;
    chk_all("gap5_stop", 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      step();
      if (done) seen = 1'b1;
    end
    chk("gap5_no_done", 32'(seen), 32'd0);

    // RESET during idx 9
    play = 1'b1;
    step();
    play = 1'b0;
    repeat (92) step();
    chk("idx9.note", 32'(note_out), 32'd1);
    #2 RESET = 1'b1;
    #1;
    chk_all("reset_mid", 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    RESET = 1'b0;
    step();
    chk_all("reset_hold", 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    play = 1'b1;
    step();
    play = 1'b0;
    chk_all("restart", 4'd3, 8'h04, 1'b1, 1'b0, 1'b0);

    // Bounded wait for the end-of-song pulse from a fresh start
    cnt = 1;
    while (!done && cnt < 400) begin
      step();
      cnt++;
    end
    chk("done_latency", 32'(cnt), 32'd159);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
